// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Central pipeline sequencer for the 5-stage core. Owns the stall, flush and
// bubble controls for the IF/ID and ID/EX registers and the PC. It also holds
// a table of 2-bit saturating branch-history counters. The table predicts at
// fetch (IF_take) and is trained from EX resolution.
//
// Parameters
//   BHT_DEPTH   number of 2-bit counters (power of two, 4..256)
//   MEM_TIMEOUT busy cycles tolerated in MEMWAIT before mem_err (2..1023)
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   IF_pc / IF_take     fetch address / taken prediction for it
//   ID_rs1, ID_rs2      sources of the instruction in ID
//   ID_EX_rd            destination of the instruction in EX
//   ID_EX_mem_read      instruction in EX is a load
//   EX_branch, EX_zero  EX holds a conditional branch / its outcome (1 = taken)
//   EX_take, EX_pc      prediction made for that branch / its address
//   dmem_busy           data memory not ready
//   pc_hold, EX_stall   freeze PC / hold IF/ID
//   ex_hold             hold ID/EX and later stages
//   flush               squash IF/ID and ID/EX (mispredict)
//   id_ex_bubble        load a NOP into ID/EX
//   mem_err             sticky memory-timeout flag
//   state               FSM state (RUN=0, LDUSE=1, MEMWAIT=2, ERR=3)
//
// Optional build macro PIPE_HAZARD_PERF_EN adds the perf_stall_cnt,
// perf_flush_cnt and perf_br_cnt outputs. These are free-running 32-bit
// event counters.
//
// All controls are combinational from the registered state and the current
// inputs. The controls are gated by reset, so asserting reset drops them at
// once.

module pipe_hazard_ctrl #(
  parameter int unsigned BHT_DEPTH   = 16,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IF_pc,
  output logic        IF_take,
  input  logic [4:0]  ID_rs1,
  input  logic [4:0]  ID_rs2,
  input  logic [4:0]  ID_EX_rd,
  input  logic        ID_EX_mem_read,
  input  logic        EX_branch,
  input  logic        EX_zero,
  input  logic        EX_take,
  input  logic [31:0] EX_pc,
  input  logic        dmem_busy,
  output logic        pc_hold,
  output logic        EX_stall,
  output logic        ex_hold,
  output logic        flush,
  output logic        id_ex_bubble,
  output logic        mem_err,
  output logic [1:0]  state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_br_cnt
`endif
);

  localparam int unsigned IW      = $clog2(BHT_DEPTH);
  localparam logic [9:0]  TIMEOUT = 10'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDUSE   = 2'd1,
    MEMWAIT = 2'd2,
    ERR     = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] wait_cnt_q, wait_cnt_d;

  logic          hold_c;
  logic          stall_c;
  logic          bubble_c;
  logic          flush_c;
  logic          mispredict;
  logic          lduse;
  logic          train;
  logic [IW-1:0] if_idx;
  logic [IW-1:0] ex_idx;
  logic [1:0]    ex_ctr;
  logic [1:0]    ex_ctr_next;
  logic [1:0]    bht_rd [BHT_DEPTH];

  // Only the word-index bits of the PCs select a counter.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{IF_pc[31:IW+2], IF_pc[1:0], EX_pc[31:IW+2], EX_pc[1:0]};

  assign if_idx = IF_pc[IW+1:2];
  assign ex_idx = EX_pc[IW+1:2];

  // ---------------------------------------------------------------------------
  // Hazard detection
  // ---------------------------------------------------------------------------
  // ex_hold is high in any state while memory is busy, and always high in ERR.
  // It must be resolved before mispredict, because a held EX stage neither
  // flushes nor trains.
  assign hold_c     = dmem_busy | (state_q == ERR);
  assign mispredict = EX_branch & (EX_zero != EX_take) & ~hold_c;
  assign lduse      = ID_EX_mem_read & (ID_EX_rd != 5'd0) &
                      ((ID_EX_rd == ID_rs1) | (ID_EX_rd == ID_rs2));
  assign train      = EX_branch & ~hold_c;

  // The cycle in which a memory wait releases is quiet, so a flush is
  // suppressed there as well.
  assign flush_c = mispredict & (state_q != MEMWAIT);

  // ---------------------------------------------------------------------------
  // Sequencer next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    stall_c    = 1'b0;
    bubble_c   = 1'b0;
    case (state_q)
      RUN, LDUSE: begin
        if (dmem_busy) begin
          stall_c    = 1'b1;
          state_d    = MEMWAIT;
          wait_cnt_d = 10'd1;
        end else if (mispredict) begin
          state_d = RUN;
        end else if ((state_q == RUN) && lduse) begin
          // LDUSE never re-raises the bubble, so each hazard costs one cycle.
          stall_c  = 1'b1;
          bubble_c = 1'b1;
          state_d  = LDUSE;
        end else begin
          state_d = RUN;
        end
      end
      MEMWAIT: begin
        if (dmem_busy) begin
          stall_c = 1'b1;
          if (wait_cnt_q == TIMEOUT) begin
            state_d = ERR;
          end else begin
            state_d    = MEMWAIT;
            wait_cnt_d = wait_cnt_q + 10'd1;
          end
        end else begin
          state_d = RUN;
        end
      end
      ERR: begin
        stall_c = 1'b1;
        state_d = ERR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pc_hold      = reset & stall_c;
  assign EX_stall     = reset & stall_c;
  assign ex_hold      = reset & hold_c;
  assign flush        = reset & flush_c;
  assign id_ex_bubble = reset & bubble_c;
  assign mem_err      = (state_q == ERR);
  assign state        = state_q;

  // ---------------------------------------------------------------------------
  // Branch history table
  // ---------------------------------------------------------------------------
  // The prediction is read combinationally. The read returns the value from
  // before any update made at the coming edge.
  assign IF_take = bht_rd[if_idx][1];
  assign ex_ctr  = bht_rd[ex_idx];

  always_comb begin
    ex_ctr_next = ex_ctr;
    if (EX_zero) begin
      if (ex_ctr != 2'b11) ex_ctr_next = ex_ctr + 2'd1;
    end else begin
      if (ex_ctr != 2'b00) ex_ctr_next = ex_ctr - 2'd1;
    end
  end

  for (genvar g = 0; g < BHT_DEPTH; g++) begin : g_bht
    logic [1:0] ctr_q;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        ctr_q <= 2'b01;
      end else if (train && (ex_idx == IW'(g))) begin
        ctr_q <= ex_ctr_next;
      end
    end

    assign bht_rd[g] = ctr_q;
  end

`ifdef PIPE_HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] perf_stall_q;
  logic [31:0] perf_flush_q;
  logic [31:0] perf_br_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_br_q    <= '0;
    end else begin
      if (pc_hold) perf_stall_q <= perf_stall_q + 32'd1;
      if (flush)   perf_flush_q <= perf_flush_q + 32'd1;
      if (train)   perf_br_q    <= perf_br_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_br_cnt    = perf_br_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (BHT_DEPTH=16, MEM_TIMEOUT=64).
// Each scenario task drives one cycle at a time and pushes the required
// outputs to a scoreboard queue. It then pops and compares the entry at the
// falling edge. The observed vector is
// {IF_take, pc_hold, EX_stall, ex_hold, flush, id_ex_bubble, mem_err, state}.

module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IF_pc;
  logic        IF_take;
  logic [4:0]  ID_rs1, ID_rs2, ID_EX_rd;
  logic        ID_EX_mem_read;
  logic        EX_branch, EX_zero, EX_take;
  logic [31:0] EX_pc;
  logic        dmem_busy;
  logic        pc_hold, EX_stall, ex_hold, flush, id_ex_bubble, mem_err;
  logic [1:0]  state;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_br_cnt;
`endif

  pipe_hazard_ctrl #(.BHT_DEPTH(16), .MEM_TIMEOUT(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_pc          (IF_pc),
    .IF_take        (IF_take),
    .ID_rs1         (ID_rs1),
    .ID_rs2         (ID_rs2),
    .ID_EX_rd       (ID_EX_rd),
    .ID_EX_mem_read (ID_EX_mem_read),
    .EX_branch      (EX_branch),
    .EX_zero        (EX_zero),
    .EX_take        (EX_take),
    .EX_pc          (EX_pc),
    .dmem_busy      (dmem_busy),
    .pc_hold        (pc_hold),
    .EX_stall       (EX_stall),
    .ex_hold        (ex_hold),
    .flush          (flush),
    .id_ex_bubble   (id_ex_bubble),
    .mem_err        (mem_err),
    .state          (state)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_br_cnt    (perf_br_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [8:0] e;
  } exp_t;

  typedef struct {
    string       nm;
    logic [31:0] ifpc;
    logic        mr;
    logic [4:0]  rd, rs1, rs2;
    logic        br, zr, tk;
    logic [31:0] expc;
    logic        busy;
    logic [8:0]  e;
  } step_t;

  exp_t        sbq[$];
  int unsigned tests  = 0;
  int unsigned failed = 0;

  function automatic logic [8:0] obs();
    return {IF_take, pc_hold, EX_stall, ex_hold, flush, id_ex_bubble, mem_err, state};
  endfunction

  function automatic logic [8:0] mk(input logic tk, ph, es, eh, fl, bb, er,
                                    input logic [1:0] st);
    return {tk, ph, es, eh, fl, bb, er, st};
  endfunction

  function automatic step_t s(input string nm, input logic [31:0] ifpc,
                              input logic mr, input logic [4:0] rd, rs1, rs2,
                              input logic br, zr, tk, input logic [31:0] expc,
                              input logic busy, input logic [8:0] e);
    step_t r;
    r.nm = nm; r.ifpc = ifpc; r.mr = mr; r.rd = rd; r.rs1 = rs1; r.rs2 = rs2;
    r.br = br; r.zr = zr; r.tk = tk; r.expc = expc; r.busy = busy; r.e = e;
    return r;
  endfunction

  task automatic idle();
    IF_pc = '0; ID_rs1 = '0; ID_rs2 = '0; ID_EX_rd = '0; ID_EX_mem_read = 1'b0;
    EX_branch = 1'b0; EX_zero = 1'b0; EX_take = 1'b0; EX_pc = '0; dmem_busy = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drives a step's inputs and queues its required outputs.
  task automatic apply(input step_t v);
    IF_pc = v.ifpc; ID_EX_mem_read = v.mr; ID_EX_rd = v.rd; ID_rs1 = v.rs1;
    ID_rs2 = v.rs2; EX_branch = v.br; EX_zero = v.zr; EX_take = v.tk;
    EX_pc = v.expc; dmem_busy = v.busy;
    sbq.push_back('{nm: v.nm, e: v.e});
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    exp_t        x;
    logic [31:0] pcs [5];
    pcs = '{32'h0, 32'h4, 32'h40, 32'h3c, 32'hffff_fffc};
    reset = 1'b1;
    idle();
    #1 reset = 1'b0;
    // Every hazard source active while reset is held: all controls stay low.
    dmem_busy = 1'b1; ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5;
    EX_branch = 1'b1; EX_zero = 1'b1; EX_take = 1'b0;
    sbq.push_back('{nm: "rst_ctl_low", e: mk(0,0,0,0,0,0,0,2'd0)});
    #1;
    x = sbq.pop_front(); tests++;
    if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    idle();
    foreach (pcs[i]) begin
      IF_pc = pcs[i];
      sbq.push_back('{nm: $sformatf("rst_take_%h", pcs[i]), e: mk(0,0,0,0,0,0,0,2'd0)});
      #0.5;
      x = sbq.pop_front(); tests++;
      if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    end
    cyc();
    reset = 1'b1;
    IF_pc = 32'h40;
    sbq.push_back('{nm: "rst_release", e: mk(0,0,0,0,0,0,0,2'd0)});
    @(negedge clk);
    x = sbq.pop_front(); tests++;
    if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lduse();
    exp_t  x;
    step_t v[$];
    v.push_back(s("lduse_c1",      0, 1, 5, 0, 5, 0,0,0, 0, 0, mk(0,1,1,0,0,1,0,2'd0)));
    v.push_back(s("lduse_c2",      0, 1, 5, 0, 5, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd1)));
    v.push_back(s("lduse_rd0_a",   0, 1, 0, 0, 0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("lduse_rd0_b",   0, 1, 0, 0, 0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("lduse_rs1",     0, 1, 7, 7, 0, 0,0,0, 0, 0, mk(0,1,1,0,0,1,0,2'd0)));
    v.push_back(s("lduse_rs1_c2",  0, 0, 0, 0, 0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd1)));
    v.push_back(s("lduse_noload",  0, 0, 7, 7, 0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("lduse_nomatch", 0, 1, 7, 6, 8, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd0)));
    foreach (v[i]) begin
      cyc();
      apply(v[i]);
      @(negedge clk);
      x = sbq.pop_front(); tests++;
      if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // The entry for 0x40 starts at 01. It is walked up to saturation and back.
  task automatic test_branch_training();
    exp_t  x;
    step_t v[$];
    v.push_back(s("br_t1_first",  32'h40, 0,0,0,0, 1,1,0, 32'h40, 0, mk(0,0,0,0,1,0,0,2'd0)));
    v.push_back(s("br_t2",        32'h40, 0,0,0,0, 1,1,1, 32'h40, 0, mk(1,0,0,0,0,0,0,2'd0)));
    v.push_back(s("br_t3_sat",    32'h40, 0,0,0,0, 1,1,1, 32'h40, 0, mk(1,0,0,0,0,0,0,2'd0)));
    v.push_back(s("br_alias_80",  32'h80, 0,0,0,0, 0,0,0, 32'h0,  0, mk(1,0,0,0,0,0,0,2'd0)));
    v.push_back(s("br_other_44",  32'h44, 0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("br_nt1",       32'h40, 0,0,0,0, 1,0,1, 32'h40, 0, mk(1,0,0,0,1,0,0,2'd0)));
    v.push_back(s("br_nt2",       32'h40, 0,0,0,0, 1,0,1, 32'h40, 0, mk(1,0,0,0,1,0,0,2'd0)));
    v.push_back(s("br_nt3",       32'h40, 0,0,0,0, 1,0,0, 32'h40, 0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("br_nt4_sat",   32'h40, 0,0,0,0, 1,0,0, 32'h40, 0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("br_t_from0",   32'h40, 0,0,0,0, 1,1,0, 32'h40, 0, mk(0,0,0,0,1,0,0,2'd0)));
    v.push_back(s("br_after_sat", 32'h40, 0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd0)));
    foreach (v[i]) begin
      cyc();
      apply(v[i]);
      @(negedge clk);
      x = sbq.pop_front(); tests++;
      if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    end
  endtask

  // ---------------------------------------------------------------------------
  // The entry for 0x40 starts at 01.
  task automatic test_mispredict();
    exp_t  x;
    step_t v[$];
    v.push_back(s("mp_flush",       32'h40, 0,0,0,0, 1,1,0, 32'h40, 0, mk(0,0,0,0,1,0,0,2'd0)));
    v.push_back(s("mp_trained",     32'h40, 0,0,0,0, 0,0,0, 32'h0,  0, mk(1,0,0,0,0,0,0,2'd0)));
    v.push_back(s("mp_busy_mask",   32'h40, 0,0,0,0, 1,1,0, 32'h40, 1, mk(1,1,1,1,0,0,0,2'd0)));
    v.push_back(s("mp_busy_rel",    32'h40, 0,0,0,0, 0,0,0, 32'h0,  0, mk(1,0,0,0,0,0,0,2'd2)));
    v.push_back(s("mp_nt_ok",       32'h40, 0,0,0,0, 1,0,0, 32'h40, 0, mk(1,0,0,0,0,0,0,2'd0)));
    v.push_back(s("mp_no_upd",      32'h40, 0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("mp_over_lduse",  32'h40, 1,5,0,5, 1,0,1, 32'h40, 0, mk(0,0,0,0,1,0,0,2'd0)));
    v.push_back(s("mp_over_lduse2", 32'h40, 0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("ld_then_mp_a",   32'h40, 1,5,0,5, 0,0,0, 32'h0,  0, mk(0,1,1,0,0,1,0,2'd0)));
    v.push_back(s("ld_then_mp_b",   32'h40, 1,5,0,5, 1,1,0, 32'h40, 0, mk(0,0,0,0,1,0,0,2'd1)));
    v.push_back(s("ld_then_mp_c",   32'h40, 0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd0)));
    v.push_back(s("ld_then_busy_a", 32'h0,  1,5,0,5, 0,0,0, 32'h0,  0, mk(0,1,1,0,0,1,0,2'd0)));
    v.push_back(s("ld_then_busy_b", 32'h0,  1,5,0,5, 0,0,0, 32'h0,  1, mk(0,1,1,1,0,0,0,2'd1)));
    v.push_back(s("ld_then_busy_c", 32'h0,  0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd2)));
    v.push_back(s("ld_then_busy_d", 32'h0,  0,0,0,0, 0,0,0, 32'h0,  0, mk(0,0,0,0,0,0,0,2'd0)));
    foreach (v[i]) begin
      cyc();
      apply(v[i]);
      @(negedge clk);
      x = sbq.pop_front(); tests++;
      if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_memwait();
    exp_t  x;
    step_t v[$];
    for (int i = 0; i < 5; i++)
      v.push_back(s($sformatf("mw5_busy%0d", i), 0, 0,0,0,0, 0,0,0, 0, 1,
                    mk(0,1,1,1,0,0,0, (i == 0) ? 2'd0 : 2'd2)));
    v.push_back(s("mw5_release", 0, 0,0,0,0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd2)));
    v.push_back(s("mw5_run",     0, 0,0,0,0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd0)));
    // Exactly MEM_TIMEOUT busy cycles are still tolerated.
    for (int i = 0; i < 64; i++)
      v.push_back(s($sformatf("mw64_busy%0d", i), 0, 0,0,0,0, 0,0,0, 0, 1,
                    mk(0,1,1,1,0,0,0, (i == 0) ? 2'd0 : 2'd2)));
    v.push_back(s("mw64_release", 0, 0,0,0,0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd2)));
    v.push_back(s("mw64_run",     0, 0,0,0,0, 0,0,0, 0, 0, mk(0,0,0,0,0,0,0,2'd0)));
    foreach (v[i]) begin
      cyc();
      apply(v[i]);
      @(negedge clk);
      x = sbq.pop_front(); tests++;
      if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    exp_t  x;
    step_t v[$];
    for (int i = 0; i < 65; i++)
      v.push_back(s($sformatf("to_busy%0d", i), 0, 0,0,0,0, 0,0,0, 0, 1,
                    mk(0,1,1,1,0,0,0, (i == 0) ? 2'd0 : 2'd2)));
    v.push_back(s("to_err",       0,      0,0,0,0, 0,0,0, 0,      0, mk(0,1,1,1,0,0,1,2'd3)));
    v.push_back(s("to_err_nomp",  32'h40, 0,0,0,0, 1,1,0, 32'h40, 0, mk(0,1,1,1,0,0,1,2'd3)));
    v.push_back(s("to_err_stuck", 32'h40, 1,5,5,0, 0,0,0, 0,      0, mk(0,1,1,1,0,0,1,2'd3)));
    foreach (v[i]) begin
      cyc();
      apply(v[i]);
      @(negedge clk);
      x = sbq.pop_front(); tests++;
      if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    end
    // Reset mid-stall clears every control without waiting for an edge.
    cyc();
    idle();
    IF_pc = 32'h40;
    reset = 1'b0;
    sbq.push_back('{nm: "to_reset_async", e: mk(0,0,0,0,0,0,0,2'd0)});
    #1;
    x = sbq.pop_front(); tests++;
    if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
    cyc();
    reset = 1'b1;
    sbq.push_back('{nm: "to_reset_run", e: mk(0,0,0,0,0,0,0,2'd0)});
    @(negedge clk);
    x = sbq.pop_front(); tests++;
    if (obs() !== x.e) begin failed++; $display("FAIL %s: got %b required %b", x.nm, obs(), x.e); end
  endtask

`ifdef PIPE_HAZARD_PERF_EN
  // ---------------------------------------------------------------------------
  task automatic test_perf();
    cyc();
    idle();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5;
    cyc();
    idle();
    cyc();
    EX_branch = 1'b1; EX_zero = 1'b1; EX_take = 1'b0; EX_pc = 32'h40;
    cyc();
    idle();
    @(negedge clk);
    tests++;
    if (perf_stall_cnt !== 32'd1) begin failed++; $display("FAIL perf_stall: got %0d required 1", perf_stall_cnt); end
    tests++;
    if (perf_flush_cnt !== 32'd1) begin failed++; $display("FAIL perf_flush: got %0d required 1", perf_flush_cnt); end
    tests++;
    if (perf_br_cnt !== 32'd1) begin failed++; $display("FAIL perf_br: got %0d required 1", perf_br_cnt); end
    // Wrap: preload all-ones, then produce one event of each kind.
    cyc();
    dut.perf_flush_q = 32'hffff_ffff;
    EX_branch = 1'b1; EX_zero = 1'b1; EX_take = 1'b0; EX_pc = 32'h40;
    cyc();
    idle();
    dut.perf_stall_q = 32'hffff_ffff;
    ID_EX_mem_read = 1'b1; ID_EX_rd = 5'd5; ID_rs2 = 5'd5;
    cyc();
    idle();
    @(negedge clk);
    tests++;
    if (perf_flush_cnt !== 32'd0) begin failed++; $display("FAIL perf_flush_wrap: got %h required 0", perf_flush_cnt); end
    tests++;
    if (perf_stall_cnt !== 32'd0) begin failed++; $display("FAIL perf_stall_wrap: got %h required 0", perf_stall_cnt); end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lduse();
    test_branch_training();
    test_mispredict();
    test_memwait();
    test_timeout();
`ifdef PIPE_HAZARD_PERF_EN
    test_perf();
`endif
    if (sbq.size() != 0) begin
      tests++;
      failed++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
